// File: rtl/alu_8_mul_seq_if.sv
// Bundle between the shift-add multiplier controller, its requester and the
// 8-bit arithmetic unit.
//   start/mcand/mplier : request and operands from the requester
//   busy/done/product  : status and registered 16-bit result to the requester
//   AluA/AluB/AluOp    : operands and opcode driven to the arithmetic unit
//   AluResult/AluCout  : sum and carry returned by the arithmetic unit
// The master modport is the environment side (requester plus arithmetic unit).
// The slave modport is the controller side.
interface alu_8_mul_seq_if;
  localparam int unsigned DW = 8;
  localparam int unsigned PW = 16;
  localparam int unsigned OW = 3;

  logic          start;
  logic [DW-1:0] mcand;
  logic [DW-1:0] mplier;
  logic          busy;
  logic          done;
  logic [PW-1:0] product;
  logic [DW-1:0] AluA;
  logic [DW-1:0] AluB;
  logic [OW-1:0] AluOp;
  logic [DW-1:0] AluResult;
  logic          AluCout;

  modport master (
    output start, mcand, mplier, AluResult, AluCout,
    input  busy, done, product, AluA, AluB, AluOp
  );

  modport slave (
    input  start, mcand, mplier, AluResult, AluCout,
    output busy, done, product, AluA, AluB, AluOp
  );
endinterface

// File: rtl/alu_8_mul_seq.sv
// Sequential 8x8 unsigned shift-add multiplier controller.
// One add per iteration is performed on the external 8-bit arithmetic unit.
// The 16-bit shift is done locally.
//   clk   : system clock, rising edge
//   rst_n : asynchronous active-low reset
//   bus   : slave side of alu_8_mul_seq_if, which carries the start/busy/done
//           handshake, the operands, the product and the arithmetic unit
//           signals
module alu_8_mul_seq #(
  parameter int unsigned N_ITER = 8,
  parameter logic [2:0]  OP_ADD = 3'b000
) (
  input  logic               clk,
  input  logic               rst_n,
  alu_8_mul_seq_if.slave     bus
);
  localparam int unsigned DW    = 8;
  localparam int unsigned PW    = 2 * DW;
  localparam int unsigned CNT_W = (N_ITER > 1) ? $clog2(N_ITER) : 1;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ADD   = 2'd1,
    SHIFT = 2'd2,
    DONE  = 2'd3
  } state_t;

  state_t           state, state_nxt;
  logic [PW-1:0]    acc, acc_nxt;
  logic [DW-1:0]    mcand_r, mcand_nxt;
  logic [CNT_W-1:0] cnt, cnt_nxt;
  logic             carry_r, carry_nxt;
  logic [PW-1:0]    product_r, product_nxt;
  logic             busy_r, busy_nxt;
  logic             done_r, done_nxt;

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next-state and datapath update
  always_comb begin
    state_nxt   = state;
    acc_nxt     = acc;
    mcand_nxt   = mcand_r;
    cnt_nxt     = cnt;
    carry_nxt   = carry_r;
    product_nxt = product_r;
    done_nxt    = 1'b0;

    unique case (state)
      IDLE: begin
        if (bus.start) begin
          acc_nxt   = {DW'(0), bus.mplier};
          mcand_nxt = bus.mcand;
          cnt_nxt   = '0;
          carry_nxt = 1'b0;
          state_nxt = ADD;
        end
      end
      ADD: begin
        // The carry is kept so that the following shift keeps the full
        // 9-bit partial sum.
        if (acc[0]) begin
          acc_nxt[PW-1:DW] = bus.AluResult;
          carry_nxt        = bus.AluCout;
        end
        state_nxt = SHIFT;
      end
      SHIFT: begin
        acc_nxt   = {carry_r, acc[PW-1:1]};
        carry_nxt = 1'b0;
        cnt_nxt   = cnt + CNT_W'(1);
        state_nxt = (cnt == CNT_W'(N_ITER - 1)) ? DONE : ADD;
      end
      DONE: begin
        product_nxt = acc;
        done_nxt    = 1'b1;
        state_nxt   = IDLE;
      end
      default: state_nxt = IDLE;
    endcase

    busy_nxt = (state_nxt != IDLE);
  end

  // Datapath and status registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc       <= '0;
      mcand_r   <= '0;
      cnt       <= '0;
      carry_r   <= 1'b0;
      product_r <= '0;
      busy_r    <= 1'b0;
      done_r    <= 1'b0;
    end else begin
      acc       <= acc_nxt;
      mcand_r   <= mcand_nxt;
      cnt       <= cnt_nxt;
      carry_r   <= carry_nxt;
      product_r <= product_nxt;
      busy_r    <= busy_nxt;
      done_r    <= done_nxt;
    end
  end

  assign bus.AluA    = acc[PW-1:DW];
  assign bus.AluB    = mcand_r;
  assign bus.AluOp   = OP_ADD;
  assign bus.busy    = busy_r;
  assign bus.done    = done_r;
  assign bus.product = product_r;
endmodule
